// File: rtl/mor1kx_rf_read_cappuccino_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mor1kx_rf_read_cappuccino_pkg                                            |
// | Shared constants and types for the cappuccino register-file read side.  |
// | Contents: r0 address, number of read ports, operand source select type. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package mor1kx_rf_read_cappuccino_pkg;

  // Address of the hard-wired zero register (r0).
  localparam int unsigned OR1K_RF_ZERO = 0;

  // Read ports: A and B.
  localparam int unsigned C_NUM_READ_PORTS = 2;

  // Where a held operand comes from: the RAM read register, or the local
  // override register (zero, write-through or stall-refresh data).
  typedef enum logic [0:0] {
    SRC_RAM  = 1'b0,
    SRC_HELD = 1'b1
  } rf_src_e;

endpackage
`default_nettype wire

// File: rtl/mor1kx_simple_dpram_sclk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mor1kx_simple_dpram_sclk                                                 |
// | Single-clock simple dual-port RAM: one write port, one registered read  |
// | port. Contents are not reset.                                            |
// | Ports: clk; raddr/re -> dout (registered, updates only when re=1);      |
// |        waddr/we/din write port.                                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  generate
    if (ENABLE_BYPASS != 0) begin : g_bypass
      // Same-edge write to the read address is forwarded into the read register.
      always_ff @(posedge clk) begin
        if (re) begin
          rdata_q <= (we && (waddr == raddr)) ? din : mem[raddr];
        end
      end
    end else begin : g_no_bypass
      // Same-edge write is not visible: the old contents are returned.
      always_ff @(posedge clk) begin
        if (re) begin
          rdata_q <= mem[raddr];
        end
      end
    end
  endgenerate

  assign dout = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mor1kx_rf_read_cappuccino.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mor1kx_rf_read_cappuccino                                                |
// | Register-file read side of the cappuccino pipeline. Holds the GPRs,     |
// | accepts one writeback per cycle and delivers two registered operands    |
// | to execute one cycle after decode advances, with write-through on       |
// | same-edge collisions and refresh of held operands during stalls.        |
// | Ports: clk, rst (sync, active-high); padv_decode_i, pipeline_flush_i;   |
// |        rfa_adr_i/rfb_adr_i read addresses; rf_we_i/rf_waddr_i/          |
// |        rf_result_i writeback; rfa_o/rfb_o operands; rfa_adr_o/rfb_adr_o |
// |        captured addresses; rf_valid_o operand-valid flag.               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mor1kx_rf_read_cappuccino
  import mor1kx_rf_read_cappuccino_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            pipeline_flush_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
  input  logic                            rf_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rf_waddr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_result_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_o,
  output logic                            rf_valid_o
);

  localparam logic [OPTION_RF_ADDR_WIDTH-1:0] c_zero_adr =
    OPTION_RF_ADDR_WIDTH'(OR1K_RF_ZERO);

  // Array write: r0 writes and writes during reset never reach storage.
  logic ram_we;
  assign ram_we = rf_we_i && !rst && (rf_waddr_i != c_zero_adr);

  logic [OPTION_RF_ADDR_WIDTH-1:0] adr_in   [C_NUM_READ_PORTS];
  logic [OPTION_RF_ADDR_WIDTH-1:0] adr_out  [C_NUM_READ_PORTS];
  logic [OPTION_OPERAND_WIDTH-1:0] data_out [C_NUM_READ_PORTS];

  assign adr_in[0] = rfa_adr_i;
  assign adr_in[1] = rfb_adr_i;

  generate
    for (genvar p = 0; p < C_NUM_READ_PORTS; p++) begin : g_port
      logic [OPTION_RF_ADDR_WIDTH-1:0] adr_q, adr_d;
      logic [OPTION_OPERAND_WIDTH-1:0] held_q, held_d;
      rf_src_e                         src_q, src_d;
      logic [OPTION_OPERAND_WIDTH-1:0] ram_dout;

      // The RAM read register only moves on padv, so while stalled it keeps
      // the contents sampled at capture; any later write to the held address
      // is caught by the override register below.
      mor1kx_simple_dpram_sclk #(
        .ADDR_WIDTH   (OPTION_RF_ADDR_WIDTH),
        .DATA_WIDTH   (OPTION_OPERAND_WIDTH),
        .ENABLE_BYPASS(0)
      ) u_ram (
        .clk  (clk),
        .raddr(adr_in[p]),
        .re   (padv_decode_i),
        .waddr(rf_waddr_i),
        .we   (ram_we),
        .din  (rf_result_i),
        .dout (ram_dout)
      );

      always_comb begin
        adr_d  = adr_q;
        held_d = held_q;
        src_d  = src_q;
        if (padv_decode_i) begin
          adr_d = adr_in[p];
          if (adr_in[p] == c_zero_adr) begin
            src_d  = SRC_HELD;
            held_d = '0;
          end else if (rf_we_i && (rf_waddr_i == adr_in[p])) begin
            // RAM read returns the pre-write contents; forward the result.
            src_d  = SRC_HELD;
            held_d = rf_result_i;
          end else begin
            src_d  = SRC_RAM;
          end
        end else if (rf_we_i && (rf_waddr_i == adr_q) && (adr_q != c_zero_adr)) begin
          // Stall refresh: a write landed on the operand we are holding.
          src_d  = SRC_HELD;
          held_d = rf_result_i;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          adr_q  <= '0;
          held_q <= '0;
          src_q  <= SRC_HELD;
        end else begin
          adr_q  <= adr_d;
          held_q <= held_d;
          src_q  <= src_d;
        end
      end

      assign adr_out[p]  = adr_q;
      assign data_out[p] = (src_q == SRC_RAM) ? ram_dout : held_q;
    end
  endgenerate

  logic valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (pipeline_flush_i) begin
      valid_d = 1'b0;
    end else if (padv_decode_i) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rfa_o      = data_out[0];
  assign rfb_o      = data_out[1];
  assign rfa_adr_o  = adr_out[0];
  assign rfb_adr_o  = adr_out[1];
  assign rf_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_rf_read_cappuccino.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mor1kx_rf_read_cappuccino                                             |
// | Self-checking bench: directed vectors, a register-level reference model |
// | compared every cycle, and literal expectations at key points.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mor1kx_rf_read_cappuccino;

  logic        clk;
  logic        rst;
  logic        padv_decode_i;
  logic        pipeline_flush_i;
  logic [4:0]  rfa_adr_i;
  logic [4:0]  rfb_adr_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_result_i;
  logic [31:0] rfa_o;
  logic [31:0] rfb_o;
  logic [4:0]  rfa_adr_o;
  logic [4:0]  rfb_adr_o;
  logic        rf_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  mor1kx_rf_read_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .padv_decode_i   (padv_decode_i),
    .pipeline_flush_i(pipeline_flush_i),
    .rfa_adr_i       (rfa_adr_i),
    .rfb_adr_i       (rfb_adr_i),
    .rf_we_i         (rf_we_i),
    .rf_waddr_i      (rf_waddr_i),
    .rf_result_i     (rf_result_i),
    .rfa_o           (rfa_o),
    .rfb_o           (rfb_o),
    .rfa_adr_o       (rfa_adr_o),
    .rfb_adr_o       (rfb_adr_o),
    .rf_valid_o      (rf_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: each operand port shows the current value of the
  // register whose address it holds; r0 is always zero.
  logic [31:0] m_mem [32];
  bit   [31:0] m_known = 32'h1;
  logic [4:0]  m_aa = '0, m_ab = '0;
  bit          m_valid = 1'b0;
  bit          started = 1'b0;

  function automatic logic [31:0] m_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_aa    <= '0;
      m_ab    <= '0;
      m_valid <= 1'b0;
      started <= 1'b1;
    end else begin
      if (rf_we_i && rf_waddr_i != 5'd0) begin
        m_mem[rf_waddr_i]   <= rf_result_i;
        m_known[rf_waddr_i] <= 1'b1;
      end
      if (padv_decode_i) begin
        m_aa <= rfa_adr_i;
        m_ab <= rfb_adr_i;
      end
      m_valid <= pipeline_flush_i ? 1'b0 : (padv_decode_i ? 1'b1 : m_valid);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_rfa_adr", {27'b0, rfa_adr_o}, {27'b0, m_aa});
      chk("model_rfb_adr", {27'b0, rfb_adr_o}, {27'b0, m_ab});
      chk("model_valid",   {31'b0, rf_valid_o}, {31'b0, m_valid});
      if (m_known[m_aa]) chk("model_rfa", rfa_o, m_val(m_aa));
      if (m_known[m_ab]) chk("model_rfb", rfb_o, m_val(m_ab));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit padv, input bit fl,
                       input logic [4:0] aa, input logic [4:0] ab,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    rst              = r;
    padv_decode_i    = padv;
    pipeline_flush_i = fl;
    rfa_adr_i        = aa;
    rfb_adr_i        = ab;
    rf_we_i          = we;
    rf_waddr_i       = wa;
    rf_result_i      = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return (i == 7) ? 32'h1 : (32'hC0DE0000 | i);
  endfunction

  initial begin
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("reset_rfa",   rfa_o, 32'h0);
    chk("reset_rfb",   rfb_o, 32'h0);
    chk("reset_valid", {31'b0, rf_valid_o}, 32'h0);
    idle();
    chk("idle_rfa_adr", {27'b0, rfa_adr_o}, 32'h0);
    chk("idle_valid",   {31'b0, rf_valid_o}, 32'h0);

    // Known contents everywhere; r7 = 1.
    for (int i = 1; i < 32; i++)
      drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'(i), fill_val(i));

    // Basic read after write.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("read_r3_rfa",   rfa_o, 32'hDEADBEEF);
    chk("read_r3_rfb",   rfb_o, 32'h0);
    chk("read_r3_valid", {31'b0, rf_valid_o}, 32'h1);

    // Same-edge collision on both ports.
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 32'h12345678);
    chk("collide_rfa", rfa_o, 32'h12345678);
    chk("collide_rfb", rfb_o, 32'h12345678);

    // Collision on port B only.
    drive(1'b0, 1'b1, 1'b0, 5'd4, 5'd6, 1'b1, 5'd6, 32'h0BADF00D);
    chk("collide_b_rfa", rfa_o, 32'hC0DE0004);
    chk("collide_b_rfb", rfb_o, 32'h0BADF00D);

    // Stall refresh.
    drive(1'b0, 1'b1, 1'b0, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0);
    chk("stall_cap_rfa", rfa_o, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 5'd8, 32'h00000077);
    chk("stall1_rfa", rfa_o, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 5'd7, 32'hA5A5A5A5);
    chk("stall2_rfa",     rfa_o, 32'hA5A5A5A5);
    chk("stall2_rfb",     rfb_o, 32'hDEADBEEF);
    chk("stall2_rfa_adr", {27'b0, rfa_adr_o}, 32'd7);
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 1'b0, 5'd0, 32'h0);
    chk("stall3_rfa",   rfa_o, 32'hA5A5A5A5);
    chk("stall3_valid", {31'b0, rf_valid_o}, 32'h1);

    // r0 stays zero, including under a stall-time write to r0.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("r0_rfa", rfa_o, 32'h0);
    chk("r0_rfb", rfb_o, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk("r0_hold_rfa", rfa_o, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk("r0_collide_rfb", rfb_o, 32'h0);

    // Write during reset is suppressed.
    drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 1'b1, 5'd1, 32'hFFFFFFFF);
    chk("rst_mid_valid", {31'b0, rf_valid_o}, 32'h0);
    chk("rst_mid_rfa",   rfa_o, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0);
    chk("rst_write_r1", rfa_o, 32'hC0DE0001);
    chk("rst_read_r2",  rfb_o, 32'hC0DE0002);

    // Flush priority over padv.
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd10, 1'b0, 5'd0, 32'h0);
    chk("flush_valid",   {31'b0, rf_valid_o}, 32'h0);
    chk("flush_rfa_adr", {27'b0, rfa_adr_o}, 32'd9);
    chk("flush_rfa",     rfa_o, 32'hC0DE0009);
    idle();
    chk("flush_hold_valid", {31'b0, rf_valid_o}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 5'd10, 5'd11, 1'b0, 5'd0, 32'h0);
    chk("post_flush_valid", {31'b0, rf_valid_o}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd11, 32'h5555AAAA);
    chk("flush_only_valid", {31'b0, rf_valid_o}, 32'h0);
    chk("flush_refresh_rfb", rfb_o, 32'h5555AAAA);
    idle();

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
